// File: rtl/gte_cop2_sequencer.sv
// In-order COP2 request sequencer feeding the GTE register/run interface.
// Optional perf counters are enabled with the GTE_SEQ_PERF_EN macro.
module gte_cop2_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_nRst,
    input  logic        i_reqValid,
    output logic        o_reqReady,
    input  logic [1:0]  i_reqOp,
    input  logic        i_reqCtrl,
    input  logic [4:0]  i_reqIdx,
    input  logic [31:0] i_reqData,
    input  logic [24:0] i_reqInstr,
    output logic        o_rdValid,
    output logic [31:0] o_rdData,
    output logic        o_busy,
    output logic [5:0]  o_regID,
    output logic        o_WritReg,
    output logic [31:0] o_wrData,
    input  logic [31:0] i_engData,
    output logic [24:0] o_Instruction,
    output logic        o_run,
    input  logic        i_executing,
    output logic [31:0] o_perfStall,
    output logic [31:0] o_perfCmds
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]  op;
        logic        bank;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [24:0] instr;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RDADDR,
        S_RDCAP,
        S_RUN,
        S_WAIT
    } state_t;

    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        new_entry;
    entry_t        head;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ready_q, ready_d;
    logic [5:0]    reg_id_q, reg_id_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [24:0]   instr_q, instr_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic          empty;
    logic          push;
    logic          pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_reqValid && ready_q;
    assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        new_entry       = '0;
        new_entry.op    = i_reqOp;
        new_entry.idx   = i_reqIdx;
        new_entry.data  = i_reqData;
        new_entry.instr = i_reqInstr;
        case (i_reqOp)
            2'd1:    new_entry.bank = 1'b1;
            2'd2:    new_entry.bank = i_reqCtrl;
            default: new_entry.bank = 1'b0;
        endcase
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= new_entry;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        reg_id_d   = reg_id_q;
        wr_data_d  = wr_data_q;
        instr_d    = instr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !i_executing) begin
                    pop = 1'b1;
                    case (head.op)
                        2'd2: begin
                            reg_id_d = {head.bank, head.idx};
                            state_d  = S_RDADDR;
                        end
                        2'd3: begin
                            instr_d = head.instr;
                            state_d = S_RUN;
                        end
                        default: begin
                            reg_id_d  = {head.bank, head.idx};
                            wr_data_d = head.data;
                            state_d   = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE:  state_d = S_IDLE;
            S_RDADDR: state_d = S_RDCAP;
            S_RDCAP: begin
                rd_data_d  = i_engData;
                rd_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_RUN:    state_d = S_WAIT;
            S_WAIT: begin
                if (!i_executing) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Ready is registered so it reads 0 in reset and reflects fullness before any same-cycle pop.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
        ready_d  = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            reg_id_q   <= '0;
            wr_data_q  <= '0;
            instr_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            reg_id_q   <= reg_id_d;
            wr_data_q  <= wr_data_d;
            instr_q    <= instr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_reqReady    = ready_q;
    assign o_rdValid     = rd_valid_q;
    assign o_rdData      = rd_data_q;
    assign o_busy        = !empty || (state_q != S_IDLE);
    assign o_regID       = reg_id_q;
    assign o_WritReg     = (state_q == S_WRITE);
    assign o_wrData      = wr_data_q;
    assign o_Instruction = instr_q;
    assign o_run         = (state_q == S_RUN);

`ifdef GTE_SEQ_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_cmds_q, perf_cmds_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, (i_reqValid && !ready_q)};
        perf_cmds_d  = perf_cmds_q + {31'd0, (state_q == S_RUN)};
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            perf_stall_q <= '0;
            perf_cmds_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_cmds_q  <= perf_cmds_d;
        end
    end

    assign o_perfStall = perf_stall_q;
    assign o_perfCmds  = perf_cmds_q;
`else
    assign o_perfStall = 32'd0;
    assign o_perfCmds  = 32'd0;
`endif

endmodule

// File: tb/tb_gte_cop2_sequencer.sv
// Scoreboard bench for gte_cop2_sequencer: GTE engine stand-in plus an
// architectural register model that predicts read data in request order.
module tb_gte_cop2_sequencer;

    logic        i_clk = 1'b0;
    logic        i_nRst;
    logic        i_reqValid;
    logic        o_reqReady;
    logic [1:0]  i_reqOp;
    logic        i_reqCtrl;
    logic [4:0]  i_reqIdx;
    logic [31:0] i_reqData;
    logic [24:0] i_reqInstr;
    logic        o_rdValid;
    logic [31:0] o_rdData;
    logic        o_busy;
    logic [5:0]  o_regID;
    logic        o_WritReg;
    logic [31:0] o_wrData;
    logic [31:0] i_engData;
    logic [24:0] o_Instruction;
    logic        o_run;
    logic        i_executing;
    logic [31:0] o_perfStall;
    logic [31:0] o_perfCmds;

    gte_cop2_sequencer #(.FIFO_DEPTH(4)) dut (
        .i_clk(i_clk), .i_nRst(i_nRst),
        .i_reqValid(i_reqValid), .o_reqReady(o_reqReady),
        .i_reqOp(i_reqOp), .i_reqCtrl(i_reqCtrl), .i_reqIdx(i_reqIdx),
        .i_reqData(i_reqData), .i_reqInstr(i_reqInstr),
        .o_rdValid(o_rdValid), .o_rdData(o_rdData), .o_busy(o_busy),
        .o_regID(o_regID), .o_WritReg(o_WritReg), .o_wrData(o_wrData),
        .i_engData(i_engData), .o_Instruction(o_Instruction), .o_run(o_run),
        .i_executing(i_executing),
        .o_perfStall(o_perfStall), .o_perfCmds(o_perfCmds)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Engine command semantics: writes a derived value into a data register.
    function automatic logic [4:0] cmdTarget(input logic [24:0] instr);
        return instr[4:0] ^ 5'd1;
    endfunction

    function automatic logic [31:0] cmdResult(input logic [24:0] instr);
        return {7'd0, instr} * 32'd3 + 32'h100;
    endfunction

    // Engine stand-in: register file, busy for eng_lat cycles after o_run.
    int          eng_lat = 2;
    int          busy_cnt = 0;
    logic        eng_init;
    logic        eng_busy;
    logic [24:0] pend_instr;
    logic [31:0] eng_regs [64];
    logic        ext_busy;
    logic        ext_rand_en;
    logic        ext_rand = 1'b0;

    always @(posedge i_clk) begin
        if (eng_init) begin
            for (int i = 0; i < 64; i++) eng_regs[i] <= 32'd0;
        end else begin
            if (o_WritReg) eng_regs[o_regID] <= o_wrData;
            if (o_run) begin
                busy_cnt   <= eng_lat;
                pend_instr <= o_Instruction;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) eng_regs[{1'b0, cmdTarget(pend_instr)}] <= cmdResult(pend_instr);
            end
        end
    end

    always @(posedge i_clk) begin
        if (!ext_rand_en)  ext_rand <= 1'b0;
        else if (ext_rand) ext_rand <= ($urandom_range(0, 3) != 0);
        else               ext_rand <= ($urandom_range(0, 11) == 0);
    end

    assign eng_busy    = (busy_cnt != 0);
    assign i_executing = eng_busy || ext_busy || ext_rand;
    assign i_engData   = eng_busy ? 32'hDEAD_BEEF : eng_regs[o_regID];

    // Reference model and scoreboard state.
    logic [31:0] mregs [64];
    logic [31:0] exp_q [$];
    int          run_count = 0;
    int          last_run_cyc = -1;
    int          last_wr_cyc = -1;
    int          last_rdv_cyc = -1;
    logic [5:0]  last_wr_id = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read data, checks the engine-busy hazard rule.
    initial begin
        logic       prev_exec;
        logic       prev_rstn;
        logic [5:0] prev_regid;
        prev_exec  = 1'b0;
        prev_rstn  = 1'b0;
        prev_regid = '0;
        forever begin
            @(negedge i_clk);
            if (i_nRst) begin
                if (o_run) begin
                    run_count++;
                    last_run_cyc = cyc;
                end
                if (o_WritReg) begin
                    last_wr_cyc = cyc;
                    last_wr_id  = o_regID;
                end
                if (o_rdValid) begin
                    last_rdv_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL rd_unexpected: got 0x%08h expected no response", o_rdData);
                    end else begin
                        checkOutput("rd_data", o_rdData, exp_q.pop_front());
                    end
                end
                if (prev_rstn && (o_WritReg || o_run || (o_regID != prev_regid))) begin
                    checks++;
                    if (prev_exec) begin
                        errors++;
                        $display("[TB] FAIL busy_hazard: got access (wr=%0b run=%0b id=0x%02h) expected none while executing",
                                 o_WritReg, o_run, o_regID);
                    end
                end
            end
            prev_exec  = i_executing;
            prev_rstn  = i_nRst;
            prev_regid = o_regID;
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic ctrl, input logic [4:0] idx,
                                 input logic [31:0] data, input logic [24:0] instr, output int pcyc);
        bit acc = 0;
        int n = 0;
        pcyc       = -1;
        i_reqValid = 1'b1;
        i_reqOp    = op;
        i_reqCtrl  = ctrl;
        i_reqIdx   = idx;
        i_reqData  = data;
        i_reqInstr = instr;
        while (!acc && n < 3000) begin
            @(negedge i_clk);
            acc  = o_reqReady && i_nRst;
            pcyc = cyc;
            @(posedge i_clk);
            #1;
            n++;
        end
        i_reqValid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got no accept expected accept within 3000 cycles");
        end else begin
            case (op)
                2'd0: mregs[{1'b0, idx}] = data;
                2'd1: mregs[{1'b1, idx}] = data;
                2'd2: exp_q.push_back(mregs[{ctrl, idx}]);
                default: mregs[{1'b0, cmdTarget(instr)}] = cmdResult(instr);
            endcase
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        bit done = 0;
        while (!done && n < 3000) begin
            @(negedge i_clk);
            done = !o_busy && !i_executing && (exp_q.size() == 0);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d expected idle", o_busy, exp_q.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"},  32'(o_reqReady), 32'd0);
        checkOutput({tag, "_rdv"},    32'(o_rdValid), 32'd0);
        checkOutput({tag, "_rddata"}, o_rdData, 32'd0);
        checkOutput({tag, "_busy"},   32'(o_busy), 32'd0);
        checkOutput({tag, "_regid"},  32'(o_regID), 32'd0);
        checkOutput({tag, "_wr"},     32'(o_WritReg), 32'd0);
        checkOutput({tag, "_wrdata"}, o_wrData, 32'd0);
        checkOutput({tag, "_instr"},  32'(o_Instruction), 32'd0);
        checkOutput({tag, "_run"},    32'(o_run), 32'd0);
        checkOutput({tag, "_pstall"}, o_perfStall, 32'd0);
        checkOutput({tag, "_pcmds"},  o_perfCmds, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pc, rc, r0, saved, rel;
        logic [31:0] va, vb, vc;
        i_nRst = 1'b0; i_reqValid = 1'b0; i_reqOp = '0; i_reqCtrl = 1'b0;
        i_reqIdx = '0; i_reqData = '0; i_reqInstr = '0;
        ext_busy = 1'b0; ext_rand_en = 1'b0; eng_init = 1'b1;
        for (int i = 0; i < 64; i++) mregs[i] = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        checkResetOutputs("reset");
        eng_init = 1'b0;
        i_nRst   = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;

        $display("[TB] write then read");
        applyStimulus(2'd0, 1'b0, 5'd5, 32'h1234_5678, 25'd0, pc);
        @(negedge i_clk);
        checkOutput("busy_after_push", 32'(o_busy), 32'd1);
        repeat (4) @(posedge i_clk);
        #1;
        checkOutput("wr_latency", last_wr_cyc, pc + 2);
        checkOutput("wr_regid", 32'(last_wr_id), 32'h05);
        applyStimulus(2'd2, 1'b0, 5'd5, 32'd0, 25'd0, pc);
        waitIdle();
        checkOutput("rd_latency", last_rdv_cyc, pc + 4);

        $display("[TB] command hazard");
        eng_lat = 20;
        r0 = run_count;
        applyStimulus(2'd3, 1'b0, 5'd0, 32'd0, 25'h0000006, pc);
        applyStimulus(2'd2, 1'b0, 5'd7, 32'd0, 25'd0, rc);
        waitIdle();
        checkOutput("cmd_run_count", run_count - r0, 1);
        checkOutput("cmd_run_latency", last_run_cyc, pc + 2);
        checkOutput("cmd_rd_latency", last_rdv_cyc, pc + 27);

        $display("[TB] full fifo");
        eng_lat = 2;
        va = $urandom; vb = $urandom; vc = $urandom;
        ext_busy = 1'b1;
        applyStimulus(2'd0, 1'b0, 5'd10, va, 25'd0, pc);
        applyStimulus(2'd0, 1'b0, 5'd10, vb, 25'd0, pc);
        applyStimulus(2'd2, 1'b0, 5'd10, 32'd0, 25'd0, pc);
        applyStimulus(2'd0, 1'b0, 5'd10, vc, 25'd0, pc);
        @(negedge i_clk);
        checkOutput("full_ready", 32'(o_reqReady), 32'd0);
        checkOutput("full_busy", 32'(o_busy), 32'd1);
        fork
            applyStimulus(2'd2, 1'b0, 5'd10, 32'd0, 25'd0, pc);
            begin
                repeat (4) @(posedge i_clk);
                #1;
                ext_busy = 1'b0;
            end
        join
        waitIdle();

        $display("[TB] external busy");
        ext_busy = 1'b1;
        saved = last_wr_cyc;
        applyStimulus(2'd1, 1'b0, 5'd20, $urandom, 25'd0, pc);
        repeat (6) @(posedge i_clk);
        #1;
        checkOutput("extbusy_no_write", last_wr_cyc, saved);
        rel = cyc;
        ext_busy = 1'b0;
        waitIdle();
        checkOutput("extbusy_write_cyc", last_wr_cyc, rel + 1);
        checkOutput("extbusy_write_id", 32'(last_wr_id), 32'h34);
        applyStimulus(2'd2, 1'b1, 5'd20, 32'd0, 25'd0, pc);
        waitIdle();

        $display("[TB] random traffic");
        ext_rand_en = 1'b1;
        for (int k = 0; k < 150; k++) begin
            eng_lat = $urandom_range(1, 8);
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          $urandom, 25'($urandom), pc);
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
            #1;
        end
        ext_rand_en = 1'b0;
        waitIdle();

        $display("[TB] reset mid-wait");
        eng_lat = 30;
        r0 = run_count;
        applyStimulus(2'd3, 1'b0, 5'd0, 32'd0, 25'($urandom), pc);
        for (int k = 0; k < 3; k++) applyStimulus(2'd2, 1'b0, 5'(k), 32'd0, 25'd0, rc);
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rst_run_issued", run_count - r0, 1);
        i_nRst = 1'b0;
        #2;
        checkResetOutputs("midrst");
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_nRst = 1'b1;
        waitIdle();
        checkOutput("postrst_busy", 32'(o_busy), 32'd0);

        $display("[TB] perf counters");
        eng_lat = 3;
        ext_busy = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(2'd3, 1'b0, 5'd0, 32'd0, 25'(k + 9), pc);
        applyStimulus(2'd0, 1'b0, 5'd3, 32'hCAFE_0003, 25'd0, pc);
        fork
            applyStimulus(2'd2, 1'b0, 5'd3, 32'd0, 25'd0, pc);
            begin
                repeat (3) @(posedge i_clk);
                #1;
                ext_busy = 1'b0;
            end
        join
        waitIdle();
`ifdef GTE_SEQ_PERF_EN
        checkOutput("perf_cmds", o_perfCmds, 32'd3);
        checkOutput("perf_stall", o_perfStall, 32'd4);
`else
        checkOutput("perf_cmds", o_perfCmds, 32'd0);
        checkOutput("perf_stall", o_perfStall, 32'd0);
`endif
        checkOutput("end_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
